// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the register file, ALU and shift units.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: XLEN / REG_ADDR_W widths, REG_ZERO index, reg_addr_t / xword_t types,
//           shift_right() helper modelling the srl/sra datapath.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Right shift as performed by the shift unit: br_unsign=1 gives srl,
  // br_unsign=0 gives sra (sign bit replicated into the vacated MSBs).
  // The two cases are kept in separate branches so the arithmetic shift
  // never ends up in an unsigned expression context.
  function automatic xword_t shift_right(input xword_t a, input logic [4:0] shamt,
                                         input logic br_unsign);
    xword_t res;
    if (br_unsign) begin
      res = a >> shamt;
    end else begin
      res = xword_t'($signed(a) >>> shamt);
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file: x0 mask plus optional write forwarding.
// Latency: zero cycles, pure mux from storage (or from the in-flight write data).
// Backpressure: none; the port is always ready and always valid.
// Ports: addr (read index), regs (committed storage x1..xN), byp_en (per-port forwarding enable),
//        fwd_vld/fwd_addr/fwd_data (write being committed this cycle), data (read result).
module regfile_rdport
  import rv32_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [1:NREGS-1],
  input  logic              byp_en,
  input  logic              fwd_vld,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] data
);

  logic is_zero;
  logic hit;

  assign is_zero = (addr == ADDR_W'(REG_ZERO));
  // fwd_vld already excludes x0 and the reset cycle; is_zero still takes
  // priority below so x0 reads can never pick up forwarded data.
  assign hit     = byp_en && fwd_vld && (fwd_addr == addr);

  always_comb begin
    data = '0;
    if (!is_zero) begin
      data = hit ? fwd_data : regs[addr];
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit RV32I integer register file: two read ports, one write port, one debug read port.
// Latency: reads are combinational; writes commit on the rising edge of i_clk.
// Backpressure: none; every port accepts a request every cycle.
// Ports: i_clk, i_rst_n (synchronous, active-low); rs1_addr/rs2_addr -> rs1_data/rs2_data;
//        rd_addr/rd_data/rd_wren write port; dbg_addr -> dbg_data (committed state, never forwarded).
module regfile
  import rv32_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_wren,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int   NREGS  = 2 ** ADDR_W;
  localparam logic BYP_EN = (BYPASS != 0);

  // No storage for x0; reads of index 0 are masked in the read ports.
  logic [DATA_W-1:0] mem [1:NREGS-1];

  logic wr_commit;

  // A write commits only outside reset and never to x0. The same qualifier
  // gates forwarding, so a write dropped by reset is never seen on a read port.
  assign wr_commit = i_rst_n && rd_wren && (rd_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_commit) begin
      mem[rd_addr] <= rd_data;
    end
  end

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd1 (
    .addr     (rs1_addr),
    .regs     (mem),
    .byp_en   (BYP_EN),
    .fwd_vld  (wr_commit),
    .fwd_addr (rd_addr),
    .fwd_data (rd_data),
    .data     (rs1_data)
  );

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd2 (
    .addr     (rs2_addr),
    .regs     (mem),
    .byp_en   (BYP_EN),
    .fwd_vld  (wr_commit),
    .fwd_addr (rd_addr),
    .fwd_data (rd_data),
    .data     (rs2_data)
  );

  // Debug port always shows committed state, so forwarding is tied off.
  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd_dbg (
    .addr     (dbg_addr),
    .regs     (mem),
    .byp_en   (1'b0),
    .fwd_vld  (wr_commit),
    .fwd_addr (rd_addr),
    .fwd_data (rd_data),
    .data     (dbg_data)
  );

endmodule
